// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit-side control blocks.
package uart_ctrl_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned REQ_W     = $clog2(N_REQ_DEF);
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    ACK
  } arb_state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after rr_ptr_i, wrapping.
module uart_rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IDX_W = REQ_W
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    cand          = '0;
    // Walk from farthest to nearest so the closest set bit after rr_ptr_i is written last.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_i} + (IDX_W+1)'(N_REQ - k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter: latches the winner's byte, stretches
// the new-data strobe for the baud domain, and acks on done edge or timeout.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ       = N_REQ_DEF,
  parameter int unsigned NEWD_HOLD   = 104,
  parameter int unsigned TIMEOUT_CYC = 2000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      tx_newd,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      err_timeout
);

  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam int unsigned HC_W = $clog2(NEWD_HOLD + 1);
  localparam int unsigned TC_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   win_idx;
  logic              win_valid;
  logic [BYTE_W-1:0] data_q, data_d, win_byte;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [TC_W-1:0]   tmo_q, tmo_d, tmo_inc;
  logic              done_q, done_rise, tmo_hit, hold_last;
  logic [N_REQ-1:0]  ack_q, ack_d, grant_oh;
  logic              err_q, err_d;

  uart_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req_i         (req),
    .rr_ptr_i      (rr_q),
    .grant_valid_o (win_valid),
    .grant_idx_o   (win_idx)
  );

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        win_byte = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // Only a fresh rising edge counts, so a done level left over from the last frame is ignored.
  assign done_rise = tx_done & ~done_q;
  assign tmo_hit   = (tmo_q == TC_W'(TIMEOUT_CYC - 1));
  assign hold_last = (hold_q == HC_W'(NEWD_HOLD - 1));
  assign tmo_inc   = (tmo_q == TC_W'(TIMEOUT_CYC)) ? tmo_q : tmo_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    data_d  = data_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          rr_d    = win_idx;
          data_d  = win_byte;
          hold_d  = '0;
          tmo_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          ack_d   = grant_oh;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (hold_last) begin
          state_d = WAIT_DONE;
        end else if (hold_q != HC_W'(NEWD_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_inc;
        // Completion on the final cycle takes priority over the timeout abort.
        if (done_rise) begin
          ack_d   = grant_oh;
          state_d = ACK;
        end else if (tmo_hit) begin
          ack_d   = grant_oh;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= ID_W'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      hold_q  <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      done_q  <= tx_done;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ack         = ack_q;
  assign tx_newd     = (state_q == LOAD);
  assign tx_data     = data_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, corner sequences and
// randomized frames checked against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int H    = 104;
  localparam int T    = 2000;
  localparam int NONE = 1000000;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic           tx_newd;
  logic [7:0]     tx_data;
  logic           tx_done;
  logic           busy;
  logic [1:0]     grant_id;
  logic           err_timeout;

  int n_chk  = 0;
  int n_pass = 0;
  int rr_m   = N - 1;
  bit last_done = 1'b0;

  typedef struct {
    logic [N-1:0] mask;
    int           gap;
    int           exp_id;
    int           exp_lat;
  } vec_t;

  vec_t tbl [10];

  uart_tx_arbiter #(
    .N_REQ       (N),
    .NEWD_HOLD   (H),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_newd     (tx_newd),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
  endtask

  // Round-robin rule: first set bit strictly after the last winner, wrapping.
  function automatic int pick(int ptr, logic [N-1:0] m);
    for (int i = 1; i <= N; i++) begin
      if (m[(ptr + i) % N]) return (ptr + i) % N;
    end
    return 0;
  endfunction

  // tx_done waveform, indexed by cycles since the strobe first appeared.
  function automatic bit dv(int c, int s1, int w1, int s2, int w2);
    return (c >= s1 && c < s1 + w1) || (c >= s2 && c < s2 + w2);
  endfunction

  task automatic frame(input int exp_id, input logic [7:0] exp_byte, input int exp_lat,
                       input int s1, input int w1, input int s2, input int w2,
                       input bit scramble, output bit completed);
    int lat, c, nh, ack_at, exp_at;
    bit quiet, exp_to;
    exp_at = T;
    exp_to = 1'b1;
    for (int k = H; k <= T - 1; k++) begin
      if (dv(k, s1, w1, s2, w2) && !dv(k - 1, s1, w1, s2, w2)) begin
        exp_at = k + 1;
        exp_to = 1'b0;
        break;
      end
    end
    completed = !exp_to;

    lat   = 0;
    quiet = 1'b1;
    do begin
      tx_done = dv(-1, s1, w1, s2, w2);
      tick();
      lat++;
      if (ack != '0 || err_timeout) quiet = 1'b0;
    end while (!tx_newd && lat < 8);
    chk("ack_quiet_before_grant", int'(quiet), 1);
    chk("grant_latency", lat, exp_lat);
    if (!tx_newd) return;
    chk("grant_id", int'(grant_id), exp_id);
    chk("tx_data_at_load", int'(tx_data), int'(exp_byte));
    chk("busy_in_load", int'(busy), 1);

    c      = 0;
    nh     = 1;
    ack_at = -1;
    while (ack_at < 0 && c < T + 8) begin
      tx_done = dv(c, s1, w1, s2, w2);
      if (scramble && c == 2) begin
        req      = N'($urandom);
        req_data = $urandom;
      end
      tick();
      c++;
      if (tx_newd) nh++;
      if (ack != '0 || err_timeout) ack_at = c;
    end
    tx_done = 1'b0;
    chk("newd_hold_cycles", nh, H);
    chk("ack_cycle", ack_at, exp_at);
    chk("ack_vector", int'(ack), 1 << exp_id);
    chk("err_timeout", int'(err_timeout), int'(exp_to));
    chk("tx_data_held", int'(tx_data), int'(exp_byte));
  endtask

  task automatic run(input logic [N-1:0] mask, input logic [8*N-1:0] data, input int gap,
                     input int s1, input int w1, input int s2, input int w2,
                     input bit scramble, input int force_id, input int force_lat);
    int  id, lat;
    bit  comp;
    logic [7:0] b;
    if (gap > 0) begin
      req = '0;
      repeat (gap) tick();
    end
    req      = mask;
    req_data = data;
    id  = (force_id  >= 0) ? force_id  : pick(rr_m, mask);
    lat = (force_lat >= 0) ? force_lat : ((gap == 0 && last_done) ? 2 : 1);
    b   = data[8*id +: 8];
    frame(id, b, lat, s1, w1, s2, w2, scramble, comp);
    rr_m      = id;
    last_done = comp;
  endtask

  initial begin
    int lat, gap, s1, w1, s2, w2;
    logic [N-1:0] mask;

    tbl[0] = '{4'b0100, 0, 2, 1};
    tbl[1] = '{4'b1111, 0, 3, 2};
    tbl[2] = '{4'b1111, 3, 0, 1};
    tbl[3] = '{4'b1010, 0, 1, 2};
    tbl[4] = '{4'b1010, 1, 3, 1};
    tbl[5] = '{4'b0011, 0, 0, 2};
    tbl[6] = '{4'b0011, 0, 1, 2};
    tbl[7] = '{4'b1001, 2, 3, 1};
    tbl[8] = '{4'b0110, 0, 1, 2};
    tbl[9] = '{4'b1000, 0, 3, 2};

    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    rst      = 1'b1;
    repeat (3) tick();
    chk("rst_ack", int'(ack), 0);
    chk("rst_tx_newd", int'(tx_newd), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_err_timeout", int'(err_timeout), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run(tbl[i].mask, $urandom, tbl[i].gap, H + 3*i + 1, 2, NONE, 0, 1'b0,
          tbl[i].exp_id, tbl[i].exp_lat);
    end

    // All requesters active: strict 0,1,2,3,0 with the one-cycle gap after each ack.
    run(4'b1111, 32'h4332_2110, 2, H + 5, 1, NONE, 0, 1'b0, 0, 1);
    run(4'b1111, 32'h4332_2110, 0, H + 9, 1, NONE, 0, 1'b0, 1, 2);
    run(4'b1111, 32'h4332_2110, 0, H + 1, 3, NONE, 0, 1'b0, 2, 2);
    run(4'b1111, 32'h4332_2110, 0, H,     1, NONE, 0, 1'b0, 3, 2);
    run(4'b1111, 32'h4332_2110, 0, H + 2, 1, NONE, 0, 1'b0, 0, 2);

    run(4'b0100, 32'h00A5_0000, 3, H + 10, 1, NONE, 0, 1'b0, 2, 1);

    // Stale done held across LOAD entry, dropped in WAIT_DONE: no edge, so timeout.
    run(4'b0010, $urandom, 0, -50, H + 100, NONE, 0, 1'b0, 1, -1);
    // Stale done, then a fresh edge: completion.
    run(4'b1111, $urandom, 0, -50, H + 70, H + 40, 3, 1'b0, 2, -1);
    // Transmitter silent: timeout, then the next requester is served.
    run(4'b1111, $urandom, 0, NONE, 0, NONE, 0, 1'b0, 3, -1);
    run(4'b1111, $urandom, 0, H + 5, 1, NONE, 0, 1'b0, 0, 1);
    // Done edge on the very cycle the timeout would fire.
    run(4'b0100, $urandom, 0, T - 1, 1, NONE, 0, 1'b0, 2, 2);
    // Done pulse entirely inside LOAD is ignored.
    run(4'b0001, $urandom, 0, 20, 5, NONE, 0, 1'b0, 0, -1);

    req = '0;
    repeat (2) tick();
    req      = 4'b1000;
    req_data = $urandom;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!tx_newd && lat < 8);
    chk("rstmid_grant_latency", lat, 1);
    chk("rstmid_grant_id", int'(grant_id), 3);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("rstmid_tx_newd", int'(tx_newd), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_ack", int'(ack), 0);
    chk("rstmid_err", int'(err_timeout), 0);
    chk("rstmid_grant_id_cleared", int'(grant_id), 0);
    chk("rstmid_tx_data_cleared", int'(tx_data), 0);
    rst       = 1'b0;
    rr_m      = N - 1;
    last_done = 1'b0;
    run(4'b1111, $urandom, 0, H + 7, 2, NONE, 0, 1'b0, -1, -1);

    for (int it = 0; it < 30; it++) begin
      gap  = int'($urandom_range(0, 2));
      mask = N'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) begin
        s1 = NONE; w1 = 0; s2 = NONE; w2 = 0;
      end else begin
        s1 = H - 20 + int'($urandom_range(0, 300));
        w1 = int'($urandom_range(1, 8));
        s2 = s1 + w1 + int'($urandom_range(1, 20));
        w2 = int'($urandom_range(1, 4));
      end
      run(mask, $urandom, gap, s1, w1, s2, w2, bit'($urandom_range(0, 1)), -1, -1);
    end

    req = '0;
    repeat (3) tick();
    chk("final_busy", int'(busy), 0);
    chk("final_ack", int'(ack), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
